// File: rtl/credit_accumulator_pkg.sv
// Shared coin codes, FSM encoding and coin value lookup
// for the vending credit front end.
package reseller_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_A    = 2'b01;
    localparam logic [1:0] COIN_B    = 2'b10;
    localparam logic [1:0] COIN_C    = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LOCKED  = 2'd2,
        REFUND  = 2'd3
    } state_t;

    // Callers truncate the result to their own WIDTH.
    function automatic logic [31:0] coin_val(
        input logic [1:0] code,
        input int         va,
        input int         vb,
        input int         vc
    );
        logic [31:0] v;
        v = '0;
        case (code)
            COIN_A:  v = 32'(va);
            COIN_B:  v = 32'(vb);
            COIN_C:  v = 32'(vc);
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/credit_accumulator_if.sv
// Coin/select/refund bundle between the vending
// controller and the credit accumulator.
interface credit_accumulator_if #(
    parameter int WIDTH = 8
);
    logic             coin_vld;
    logic [1:0]       coin;
    logic             sel_vld;
    logic [WIDTH-1:0] sel_price;
    logic             cancel;
    logic             done;
    logic [WIDTH-1:0] credit;
    logic [WIDTH-1:0] price;
    logic             price_vld;
    logic             coin_reject;
    logic             refund_vld;
    logic [WIDTH-1:0] refund_amt;
    logic             busy;

    modport master (
        output coin_vld, coin, sel_vld,
        output sel_price, cancel, done,
        input  credit, price, price_vld,
        input  coin_reject, refund_vld,
        input  refund_amt, busy
    );

    modport slave (
        input  coin_vld, coin, sel_vld,
        input  sel_price, cancel, done,
        output credit, price, price_vld,
        output coin_reject, refund_vld,
        output refund_amt, busy
    );
endinterface

// File: rtl/credit_accumulator_idle_timer.sv
// Idle counter: raises expire once it has counted
// TIMEOUT-1 enabled cycles since the last clear.
module idle_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    assign expire = en && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/credit_accumulator.sv
// Coin credit accumulator: collects exact change,
// latches price, refunds on cancel or idle timeout.
module credit_accumulator
    import reseller_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1000,
    parameter int VAL_A   = 1,
    parameter int VAL_B   = 5,
    parameter int VAL_C   = 10
) (
    input logic                 clk,
    input logic                 rst,
    credit_accumulator_if.slave bus
);
    state_t           state;
    logic [WIDTH-1:0] credit_q;
    logic [WIDTH-1:0] price_q;
    logic [WIDTH-1:0] amt_q;
    logic             pvld_q;
    logic             rej_q;
    logic             rvld_q;
    logic             busy_q;

    logic [WIDTH-1:0] val;
    logic [WIDTH:0]   sum;
    logic             active;
    logic             coin_ev;
    logic             expire;
    logic             go_refund;
    logic             tmr_clr;
    logic             ev_refund;
    logic             ev_done;
    logic             ev_coin;
    logic             ev_lock;
    logic             reject;

    assign val     = WIDTH'(coin_val(bus.coin, VAL_A, VAL_B, VAL_C));
    assign coin_ev = bus.coin_vld && (bus.coin != COIN_NONE);
    assign active  = (state == COLLECT) || (state == LOCKED);
    assign sum     = {1'b0, credit_q} + {1'b0, val};

    assign go_refund = active && (bus.cancel || expire);
    assign tmr_clr   = !active || go_refund
                     || coin_ev || bus.sel_vld;

    // Carry out always rejects; when locked, so does overshoot.
    assign reject = sum[WIDTH]
                 || ((state == LOCKED) && (sum[WIDTH-1:0] > price_q));

    always_comb begin
        ev_refund = 1'b0;
        ev_done   = 1'b0;
        ev_coin   = 1'b0;
        ev_lock   = 1'b0;
        if (go_refund) begin
            ev_refund = 1'b1;
        end else if ((state == LOCKED) && bus.done) begin
            ev_done = 1'b1;
        end else if (active && coin_ev) begin
            ev_coin = 1'b1;
        end else if ((state == COLLECT) && bus.sel_vld) begin
            ev_refund = (bus.sel_price < credit_q);
            ev_lock   = (bus.sel_price >= credit_q);
        end
    end

    idle_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (active),
        .expire(expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            credit_q <= '0;
            price_q  <= '0;
            amt_q    <= '0;
            pvld_q   <= 1'b0;
            rej_q    <= 1'b0;
            rvld_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rej_q  <= 1'b0;
            rvld_q <= 1'b0;
            unique case (1'b1)
                (state == IDLE) && coin_ev: begin
                    credit_q <= val;
                    busy_q   <= 1'b1;
                    state    <= COLLECT;
                end
                (state == REFUND): begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                ev_refund: begin
                    rvld_q   <= 1'b1;
                    amt_q    <= credit_q;
                    credit_q <= '0;
                    price_q  <= '0;
                    pvld_q   <= 1'b0;
                    state    <= REFUND;
                end
                ev_done: begin
                    credit_q <= '0;
                    price_q  <= '0;
                    pvld_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                ev_coin: begin
                    if (reject) begin
                        rej_q <= 1'b1;
                    end else begin
                        credit_q <= sum[WIDTH-1:0];
                    end
                end
                ev_lock: begin
                    price_q <= bus.sel_price;
                    pvld_q  <= 1'b1;
                    state   <= LOCKED;
                end
                default: ;
            endcase
        end
    end

    assign bus.credit      = credit_q;
    assign bus.price       = price_q;
    assign bus.price_vld   = pvld_q;
    assign bus.coin_reject = rej_q;
    assign bus.refund_vld  = rvld_q;
    assign bus.refund_amt  = amt_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_credit_accumulator.sv
// Scoreboard bench for credit_accumulator: directed
// scenarios plus random traffic against a cycle model.
module tb_credit_accumulator;
    localparam int W  = 8;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    credit_accumulator_if #(.WIDTH(W)) bus ();

    credit_accumulator #(
        .WIDTH  (W),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int credit;
        int price;
        int pv;
        int rej;
        int rv;
        int amt;
        int busy;
    } exp_t;

    exp_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    // Model: phase 0 idle, 1 collecting, 2 price held, 3 refunding.
    int m_ph     = 0;
    int m_credit = 0;
    int m_price  = 0;
    int m_amt    = 0;
    int m_last   = 0;
    int cyc      = 0;

    function automatic void chk(string nm, int act, int exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    function automatic int coin_value(int c);
        if (c == 1) return 1;
        if (c == 2) return 5;
        if (c == 3) return 10;
        return 0;
    endfunction

    task automatic model(input int cv, input int c,
                         input int sv, input int sp,
                         input int can, input int dn);
        exp_t e;
        int   v;
        int   coin_ev;
        int   rf;
        int   limit;
        v       = coin_value(c);
        coin_ev = (cv != 0) && (c != 0);
        rf      = 0;
        e.rej   = 0;
        if (m_ph == 0) begin
            if (coin_ev != 0) begin
                m_credit = v;
                m_ph     = 1;
                m_last   = cyc;
            end
        end else if (m_ph == 3) begin
            m_ph = 0;
        end else if (can != 0 || cyc - m_last >= TO) begin
            rf = 1;
        end else if (m_ph == 2 && dn != 0) begin
            m_credit = 0;
            m_price  = 0;
            m_ph     = 0;
        end else if (coin_ev != 0) begin
            m_last = cyc;
            limit  = (m_ph == 1) ? 255 : m_price;
            if (m_credit + v <= limit) m_credit += v;
            else e.rej = 1;
        end else if (sv != 0) begin
            m_last = cyc;
            if (m_ph == 1) begin
                if (sp < m_credit) begin
                    rf = 1;
                end else begin
                    m_price = sp;
                    m_ph    = 2;
                end
            end
        end
        if (rf != 0) begin
            m_amt    = m_credit;
            m_credit = 0;
            m_price  = 0;
            m_ph     = 3;
        end
        e.rv     = rf;
        e.credit = m_credit;
        e.price  = m_price;
        e.pv     = (m_ph == 2) ? 1 : 0;
        e.amt    = m_amt;
        e.busy   = (m_ph != 0) ? 1 : 0;
        q.push_back(e);
        cyc++;
    endtask

    task automatic step(input int cv, input int c,
                        input int sv, input int sp,
                        input int can, input int ack);
        int dn;
        @(negedge clk);
        dn = (m_ph == 2 && m_credit == m_price && ack != 0) ? 1 : 0;
        bus.coin_vld  = (cv != 0);
        bus.coin      = 2'(c);
        bus.sel_vld   = (sv != 0);
        bus.sel_price = W'(sp);
        bus.cancel    = (can != 0);
        bus.done      = (dn != 0);
        model(cv, c, sv, sp, can, dn);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic coin(input int c);
        step(1, c, 0, 0, 0, 0);
    endtask

    task automatic sample;
        #2;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, ".credit"}, int'(bus.credit), 0);
        chk({tag, ".price"}, int'(bus.price), 0);
        chk({tag, ".price_vld"}, int'(bus.price_vld), 0);
        chk({tag, ".coin_reject"}, int'(bus.coin_reject), 0);
        chk({tag, ".refund_vld"}, int'(bus.refund_vld), 0);
        chk({tag, ".refund_amt"}, int'(bus.refund_amt), 0);
        chk({tag, ".busy"}, int'(bus.busy), 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && q.size() > 0) begin
            e = q.pop_front();
            chk("mon.credit", int'(bus.credit), e.credit);
            chk("mon.price", int'(bus.price), e.price);
            chk("mon.price_vld", int'(bus.price_vld), e.pv);
            chk("mon.coin_reject", int'(bus.coin_reject), e.rej);
            chk("mon.refund_vld", int'(bus.refund_vld), e.rv);
            chk("mon.refund_amt", int'(bus.refund_amt), e.amt);
            chk("mon.busy", int'(bus.busy), e.busy);
        end
    end

    initial begin
        bus.coin_vld  = 1'b0;
        bus.coin      = 2'b00;
        bus.sel_vld   = 1'b0;
        bus.sel_price = '0;
        bus.cancel    = 1'b0;
        bus.done      = 1'b0;
        #12;
        chk_zero("por");
        @(negedge clk);
        rst = 1'b0;

        // Successive coin values accumulate.
        coin(1); sample(); chk("c2.credit1", int'(bus.credit), 1);
        coin(2); sample(); chk("c2.credit6", int'(bus.credit), 6);
        coin(3); sample(); chk("c2.credit16", int'(bus.credit), 16);
        chk("c2.busy", int'(bus.busy), 1);
        step(0, 0, 0, 0, 1, 0);
        sample(); chk("c2.refund", int'(bus.refund_amt), 16);
        idle(1);

        // Exact change with overshoot rejection.
        coin(1); coin(2);
        step(0, 0, 1, 10, 0, 0);
        sample(); chk("c3.pvld", int'(bus.price_vld), 1);
        coin(3); sample(); chk("c3.rej10", int'(bus.coin_reject), 1);
        chk("c3.keep6", int'(bus.credit), 6);
        coin(2); sample(); chk("c3.rej5", int'(bus.coin_reject), 1);
        repeat (4) coin(1);
        sample(); chk("c3.credit10", int'(bus.credit), 10);
        step(0, 0, 0, 0, 0, 1);
        sample(); chk("c3.done.credit", int'(bus.credit), 0);
        chk("c3.done.busy", int'(bus.busy), 0);
        chk("c3.done.norefund", int'(bus.refund_vld), 0);

        // Overflow at the top of the credit range.
        repeat (25) coin(3);
        sample(); chk("c4.credit250", int'(bus.credit), 250);
        coin(3); sample(); chk("c4.ovf.rej", int'(bus.coin_reject), 1);
        chk("c4.ovf.keep", int'(bus.credit), 250);
        repeat (5) coin(1);
        coin(1); sample(); chk("c4.at255.rej", int'(bus.coin_reject), 1);
        step(0, 0, 0, 0, 1, 0);
        idle(1);

        // Cancel outranks a same-cycle coin.
        coin(1); coin(2);
        step(0, 0, 1, 20, 0, 0);
        step(1, 3, 0, 0, 1, 0);
        sample(); chk("c5.rvld", int'(bus.refund_vld), 1);
        chk("c5.amt", int'(bus.refund_amt), 6);
        chk("c5.norej", int'(bus.coin_reject), 0);
        idle(1);
        sample(); chk("c5.idle.busy", int'(bus.busy), 0);
        chk("c5.idle.credit", int'(bus.credit), 0);

        // Idle timeout, then a late coin restarting the count.
        coin(2);
        idle(TO - 1); sample(); chk("c6.early", int'(bus.refund_vld), 0);
        idle(1); sample(); chk("c6.rvld", int'(bus.refund_vld), 1);
        chk("c6.amt", int'(bus.refund_amt), 5);
        idle(1);
        coin(2);
        idle(TO - 2);
        coin(1);
        idle(TO - 1); sample(); chk("c6.restart", int'(bus.refund_vld), 0);
        idle(1); sample(); chk("c6.rvld2", int'(bus.refund_vld), 1);
        chk("c6.amt2", int'(bus.refund_amt), 6);
        idle(1);

        // Asynchronous reset in the middle of collecting.
        coin(1); coin(2); coin(1);
        sample(); chk("c1.credit7", int'(bus.credit), 7);
        #1;
        rst = 1'b1;
        #1;
        chk_zero("c1.rst");
        bus.coin_vld = 1'b0;
        bus.coin     = 2'b00;
        m_ph = 0; m_credit = 0; m_price = 0; m_amt = 0;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        sample(); chk("c1.idle", int'(bus.busy), 0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                idle(TO + 2);
            end else begin
                step(($urandom_range(0, 2) == 0) ? 1 : 0,
                     int'($urandom_range(0, 3)),
                     ($urandom_range(0, 7) == 0) ? 1 : 0,
                     int'($urandom_range(0, 40)),
                     ($urandom_range(0, 40) == 0) ? 1 : 0,
                     int'($urandom_range(0, 1)));
            end
        end

        idle(2);
        #2;
        chk("sb.drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
